// File: rtl/cim_param_rx.sv
// Per-CiM parameter receiver: snoops the shared bus and turns targeted data
// streams and broadcast patch loads into local memory writes.
package cim_bus_pkg;
  localparam int N_STORAGE = 16;
  localparam int NUM_CIMS  = 64;
  localparam int TGT_W     = $clog2(NUM_CIMS);

  typedef logic [3:0] op_t;
  localparam op_t NOP                           = 4'd0;
  localparam op_t DATA_STREAM_START_OP          = 4'd1;
  localparam op_t DATA_STREAM_OP                = 4'd2;
  localparam op_t PATCH_LOAD_BROADCAST_START_OP = 4'd3;
  localparam op_t PATCH_LOAD_BROADCAST_OP       = 4'd4;

  typedef struct packed {
    op_t                         op;
    logic [2:0][N_STORAGE-1:0]   data;
    logic [TGT_W-1:0]            target_or_sender;
  } bus_t;
endpackage

module cim_param_rx
  import cim_bus_pkg::*;
#(
  parameter int CIM_ID      = 0,
  parameter int ADDR_W      = 10,
  parameter int PATCH_LEN   = 64,
  parameter int NUM_PATCHES = 60,
  parameter int PATCH_BASE  = 'h200
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_t              bus,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [15:0]       mem_wr_data,
  output logic              param_done,
  output logic              patch_done,
  output logic              busy,
  output logic              overflow_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_PATCH  = 2'd2;

  localparam logic [16:0]      P_LO  = 17'(CIM_ID * PATCH_LEN);
  localparam logic [16:0]      P_LEN = 17'(PATCH_LEN);
  localparam logic [16:0]      P_TOT = 17'(NUM_PATCHES * PATCH_LEN);
  localparam logic [TGT_W-1:0] MY_ID = TGT_W'(CIM_ID);

  logic [1:0]          state;
  logic [ADDR_W-1:0]   base;
  logic [16:0]         len, count, wr_idx, idx;
  logic [2:0][15:0]    sr;
  logic [1:0]          sr_cnt;
  logic                pw_vld;
  logic [ADDR_W-1:0]   pw_addr;
  logic [15:0]         pw_data;

  logic       hit, is_start, in_range;
  logic [1:0] n_take;

  assign hit      = (bus.target_or_sender == MY_ID);
  assign is_start = (bus.op == DATA_STREAM_START_OP) && hit;
  assign n_take   = ((len - count) > 17'd3) ? 2'd3 : 2'(len - count);
  // Single unsigned compare: idx below the window wraps to a huge offset.
  assign in_range = ((idx - P_LO) < P_LEN);
  assign busy     = (state != S_IDLE) || (sr_cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      base         <= '0;
      len          <= '0;
      count        <= '0;
      wr_idx       <= '0;
      idx          <= '0;
      sr           <= '0;
      sr_cnt       <= '0;
      pw_vld       <= 1'b0;
      pw_addr      <= '0;
      pw_data      <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      param_done   <= 1'b0;
      patch_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      mem_wr_en  <= 1'b0;
      param_done <= 1'b0;
      patch_done <= 1'b0;
      pw_vld     <= 1'b0;

      if (pw_vld) begin
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= pw_addr;
        mem_wr_data <= pw_data;
      end

      if (is_start) begin
        // A matching START preempts everything, including queued words.
        base         <= bus.data[0][ADDR_W-1:0];
        len          <= {1'b0, bus.data[1]};
        count        <= '0;
        wr_idx       <= '0;
        sr_cnt       <= '0;
        overflow_err <= 1'b0;
        state        <= S_STREAM;
      end else begin
        if (sr_cnt != 2'd0) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= base + wr_idx[ADDR_W-1:0];
          mem_wr_data <= sr[0];
          sr          <= {16'h0, sr[2], sr[1]};
          sr_cnt      <= sr_cnt - 2'd1;
          wr_idx      <= wr_idx + 17'd1;
        end

        case (state)
          S_IDLE: begin
            if (bus.op == PATCH_LOAD_BROADCAST_START_OP) begin
              idx   <= '0;
              state <= S_PATCH;
            end
          end
          S_STREAM: begin
            if (count == len && sr_cnt == 2'd0) begin
              param_done <= 1'b1;
              state      <= S_IDLE;
            end else if (bus.op == DATA_STREAM_OP && hit) begin
              if (sr_cnt != 2'd0) begin
                overflow_err <= 1'b1;
              end else if (count != len) begin
                sr     <= bus.data;
                sr_cnt <= n_take;
                count  <= count + 17'(n_take);
              end
            end
          end
          S_PATCH: begin
            if (bus.op == PATCH_LOAD_BROADCAST_START_OP) begin
              idx <= '0;
            end else if (idx == P_TOT) begin
              patch_done <= 1'b1;
              state      <= S_IDLE;
            end else if (bus.op == PATCH_LOAD_BROADCAST_OP) begin
              if (in_range) begin
                pw_vld  <= 1'b1;
                pw_addr <= ADDR_W'(PATCH_BASE) + ADDR_W'(idx - P_LO);
                pw_data <= bus.data[0];
              end
              idx <= idx + 17'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cim_param_rx.sv
// Scoreboard bench for cim_param_rx: directed bus ops push expected writes and
// done pulses (with their cycle) into queues; a negedge monitor pops and compares.
module tb_cim_param_rx;
  import cim_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bus_t        bus;
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        param_done, patch_done, busy, overflow_err;

  always #5 clk = ~clk;

  cim_param_rx #(
    .CIM_ID(2), .ADDR_W(10), .PATCH_LEN(4), .NUM_PATCHES(4), .PATCH_BASE('h200)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .param_done(param_done), .patch_done(patch_done),
    .busy(busy), .overflow_err(overflow_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [9:0] a; logic [15:0] d; } wr_t;
  wr_t wq[$];
  int  pdq[$];
  int  ptq[$];
  int  n_pass = 0;
  int  n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic miss(input string nm, input int c);
    n_chk++;
    $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", nm, c, cyc);
  endtask

  task automatic extra(input string nm);
    n_chk++;
    $display("FAIL %s: got unexpected event at cycle %0d, expected none", nm, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    wr_t w;
    int  c;
    while (wq.size() > 0 && wq[0].c < cyc) begin w = wq.pop_front(); miss("write", w.c); end
    while (pdq.size() > 0 && pdq[0] < cyc) begin c = pdq.pop_front(); miss("param_done", c); end
    while (ptq.size() > 0 && ptq[0] < cyc) begin c = ptq.pop_front(); miss("patch_done", c); end
    if (mem_wr_en) begin
      if (wq.size() == 0) extra("write");
      else begin
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.c);
        chk("wr_addr", 32'(mem_wr_addr), 32'(w.a));
        chk("wr_data", 32'(mem_wr_data), 32'(w.d));
      end
    end
    if (param_done) begin
      if (pdq.size() == 0) extra("param_done");
      else begin c = pdq.pop_front(); chk("param_done_cycle", cyc, c); end
    end
    if (patch_done) begin
      if (ptq.size() == 0) extra("patch_done");
      else begin c = ptq.pop_front(); chk("patch_done_cycle", cyc, c); end
    end
  end

  // Drives one op; e is the posedge at which the DUT samples it.
  task automatic send(input op_t op, input int tgt, input logic [15:0] d0, d1, d2,
                      output int e);
    @(negedge clk);
    #1;
    bus.op = op;
    bus.target_or_sender = 6'(tgt);
    bus.data[0] = d0;
    bus.data[1] = d1;
    bus.data[2] = d2;
    e = cyc + 1;
  endtask

  task automatic nop(input int n);
    int e;
    for (int i = 0; i < n; i++) send(NOP, 0, 16'h0, 16'h0, 16'h0, e);
  endtask

  task automatic exp_wr(input int c, input logic [9:0] a, input logic [15:0] d);
    wq.push_back('{c, a, d});
  endtask

  initial begin
    int e;
    bus = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 0);
    chk("rst_wr_data", 32'(mem_wr_data), 0);
    chk("rst_param_done", 32'(param_done), 0);
    chk("rst_patch_done", 32'(patch_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow_err), 0);
    rst = 1'b0;

    // len=5 stream: a..c, gap, d,e (f beyond len never written)
    send(DATA_STREAM_START_OP, 2, 16'h0010, 16'd5, 16'h0, e);
    send(DATA_STREAM_OP, 2, 16'hA00A, 16'hB00B, 16'hC00C, e);
    exp_wr(e + 1, 10'h010, 16'hA00A);
    exp_wr(e + 2, 10'h011, 16'hB00B);
    exp_wr(e + 3, 10'h012, 16'hC00C);
    nop(3);
    send(DATA_STREAM_OP, 2, 16'hD00D, 16'hE00E, 16'hF00F, e);
    exp_wr(e + 1, 10'h013, 16'hD00D);
    exp_wr(e + 2, 10'h014, 16'hE00E);
    pdq.push_back(e + 3);
    nop(5);
    chk("busy_after_stream", 32'(busy), 0);

    // Other target: fully ignored
    send(DATA_STREAM_START_OP, 3, 16'h0030, 16'd4, 16'h0, e);
    send(DATA_STREAM_OP, 3, 16'h1111, 16'h2222, 16'h3333, e);
    nop(1);
    chk("busy_other_target", 32'(busy), 0);
    nop(3);

    // Back-to-back data ops: second dropped, sticky overflow, START clears it
    send(DATA_STREAM_START_OP, 2, 16'h0020, 16'd6, 16'h0, e);
    send(DATA_STREAM_OP, 2, 16'h0001, 16'h0002, 16'h0003, e);
    exp_wr(e + 1, 10'h020, 16'h0001);
    exp_wr(e + 2, 10'h021, 16'h0002);
    exp_wr(e + 3, 10'h022, 16'h0003);
    send(DATA_STREAM_OP, 2, 16'h0004, 16'h0005, 16'h0006, e);
    nop(4);
    chk("overflow_set", 32'(overflow_err), 1);
    chk("busy_mid_stream", 32'(busy), 1);
    send(DATA_STREAM_START_OP, 2, 16'h0040, 16'd0, 16'h0, e);
    pdq.push_back(e + 1);
    nop(1);
    chk("overflow_cleared", 32'(overflow_err), 0);
    nop(2);
    chk("busy_after_len0", 32'(busy), 0);

    // Patch broadcast: CiM 2 owns samples 8..11
    send(PATCH_LOAD_BROADCAST_START_OP, 7, 16'h0, 16'h0, 16'h0, e);
    for (int i = 0; i < 16; i++) begin
      send(PATCH_LOAD_BROADCAST_OP, 5, 16'(16'h1000 + i), 16'h0, 16'h0, e);
      if (i >= 8 && i <= 11) exp_wr(e + 1, 10'(10'h200 + i - 8), 16'(16'h1000 + i));
      if (i == 15) ptq.push_back(e + 1);
      if (i == 3) chk("busy_patch", 32'(busy), 1);
      if (i == 5) send(DATA_STREAM_OP, 2, 16'hDEAD, 16'hBEEF, 16'hCAFE, e);
      if (i % 2 == 1 && i != 15) nop(1);
    end
    nop(3);
    chk("busy_after_patch", 32'(busy), 0);

    // Address wrap
    send(DATA_STREAM_START_OP, 2, 16'h03FE, 16'd3, 16'h0, e);
    send(DATA_STREAM_OP, 2, 16'h7001, 16'h7002, 16'h7003, e);
    exp_wr(e + 1, 10'h3FE, 16'h7001);
    exp_wr(e + 2, 10'h3FF, 16'h7002);
    exp_wr(e + 3, 10'h000, 16'h7003);
    pdq.push_back(e + 4);
    nop(6);

    // Reset mid-stream after first write
    send(DATA_STREAM_START_OP, 2, 16'h03FE, 16'd3, 16'h0, e);
    send(DATA_STREAM_OP, 2, 16'h8001, 16'h8002, 16'h8003, e);
    exp_wr(e + 1, 10'h3FE, 16'h8001);
    send(NOP, 0, 16'h0, 16'h0, 16'h0, e);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(mem_wr_en), 0);
    chk("midrst_wr_addr", 32'(mem_wr_addr), 0);
    chk("midrst_wr_data", 32'(mem_wr_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_param_done", 32'(param_done), 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    send(DATA_STREAM_OP, 2, 16'h9001, 16'h9002, 16'h9003, e);
    nop(4);
    chk("busy_after_rst", 32'(busy), 0);

    nop(3);
    chk("wq_drained", wq.size(), 0);
    chk("pdq_drained", pdq.size(), 0);
    chk("ptq_drained", ptq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
